// File: rtl/grid_scanner.sv
// Row-multiplexed LED matrix scanner: snapshots a 16x16 generation grid at frame
// boundaries and shifts each row serially to a column driver, then dwells on it.
module grid_scanner #(
  parameter int WIDTH = 256,
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int DWELL = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        grid,
  input  logic                    grid_valid,
  input  logic                    blank,
  output logic                    sdata,
  output logic                    sclk,
  output logic                    latch,
  output logic                    oe_n,
  output logic [$clog2(ROWS)-1:0] row_addr,
  output logic                    frame_done,
  output logic                    busy
);
  localparam int RW      = $clog2(ROWS);
  localparam int CNT_MAX = (2 * COLS > DWELL) ? 2 * COLS : DWELL;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_DWELL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    r_q, r_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;

  logic             sdata_q, sdata_d;
  logic             sclk_q, sclk_d;
  logic             latch_q, latch_d;
  logic             oe_n_q, oe_n_d;
  logic [RW-1:0]    row_addr_q, row_addr_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic [COLS-1:0]  row_bits;
  logic             start;
  logic             last_dwell;

  // Outputs are decoded from the current state and registered, so every
  // output lags the state by one cycle and no input reaches an output directly.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    r_d          = r_q;
    snap_d       = snap_q;
    pend_d       = grid_valid ? grid : pend_q;
    pend_v_d     = pend_v_q;
    start        = pend_v_q | grid_valid;
    row_bits     = snap_q[(WIDTH - 1 - COLS * int'(r_q)) -: COLS];
    last_dwell   = (state_q == S_DWELL) && (cnt_q == CW'(DWELL - 1));
    sdata_d      = 1'b0;
    sclk_d       = 1'b0;
    latch_d      = 1'b0;
    oe_n_d       = 1'b1;
    frame_done_d = 1'b0;
    row_addr_d   = row_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        snap_d   = pend_q;
        pend_v_d = 1'b0;
        r_d      = '0;
        cnt_d    = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        // Even count: present the bit; odd count: hold it and raise sclk.
        sdata_d = row_bits[COLS - 1 - int'(cnt_q >> 1)];
        sclk_d  = cnt_q[0];
        if (cnt_q == CW'(2 * COLS - 1)) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        latch_d    = 1'b1;
        row_addr_d = r_q;
        cnt_d      = '0;
        state_d    = S_DWELL;
      end
      S_DWELL: begin
        oe_n_d = blank;
        if (last_dwell) begin
          cnt_d = '0;
          if (r_q != RW'(ROWS - 1)) begin
            r_d     = r_q + 1'b1;
            state_d = S_SHIFT;
          end else begin
            // A grid arriving in this very cycle still wins the next LOAD.
            frame_done_d = 1'b1;
            if (start) begin
              state_d = S_LOAD;
            end else begin
              r_d     = '0;
              state_d = S_SHIFT;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grid_valid) pend_v_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      r_q          <= '0;
      snap_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      sdata_q      <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      r_q          <= r_d;
      snap_q       <= snap_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      sdata_q      <= sdata_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      row_addr_q   <= row_addr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign sdata      = sdata_q;
  assign sclk       = sclk_q;
  assign latch      = latch_q;
  assign oe_n       = oe_n_q;
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
